// File: rtl/exmem_skid_stage.sv
// EX->MEM pipeline stage: valid/ready handshake with a registered in_ready and a 2-entry skid buffer.
// Optional operand-forwarding taps are enabled by defining EXMEM_FWD_EN.
module exmem_skid_stage #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              reg_write_en_i,
  input  logic              mem_write_en_i,
  input  logic              mem_to_reg_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] reg_data2_i,
  input  logic [ADDR_W-1:0] reg_write_addr_i,
`ifdef EXMEM_FWD_EN
  output logic              fwd_valid_o,
  output logic [ADDR_W-1:0] fwd_addr_o,
  output logic [DATA_W-1:0] fwd_data_o,
`endif
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              reg_write_en_o,
  output logic              mem_write_en_o,
  output logic              mem_to_reg_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [DATA_W-1:0] reg_data2_o,
  output logic [ADDR_W-1:0] reg_write_addr_o
);

  // Payload layout: {reg_write_en, mem_write_en, mem_to_reg, alu, reg_data2, reg_write_addr}
  localparam int PAY_W  = 3 + 2 * DATA_W + ADDR_W;
  localparam int RWE_B  = PAY_W - 1;
  localparam int MWE_B  = PAY_W - 2;
  localparam int M2R_B  = PAY_W - 3;
  localparam int ALU_LO = DATA_W + ADDR_W;
  localparam int RD2_LO = ADDR_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic [PAY_W-1:0]   main_q, main_d;
  logic [PAY_W-1:0]   skid_q, skid_d;
  logic [PAY_W-1:0]   in_pay;
  logic               main_vld;
  logic               accept;
  logic               consume;

  assign in_pay   = {reg_write_en_i, mem_write_en_i, mem_to_reg_i,
                     alu_i, reg_data2_i, reg_write_addr_i};
  assign main_vld = (state_q != EMPTY);
  assign accept   = in_valid_i & in_ready_q;
  assign consume  = main_vld & out_ready_i;

  // State register and payload registers; reset clears payloads so outputs read 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      // Squash: drop held entries and the presented input; payloads keep last value.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_pay;
            state_d = FULL;
          end
        end
        FULL: begin
          if (consume && accept) begin
            main_d = in_pay;
          end else if (consume) begin
            state_d = EMPTY;
          end else if (accept) begin
            skid_d  = in_pay;
            state_d = SKID;
          end
        end
        SKID: begin
          if (consume) begin
            main_d  = skid_q;
            state_d = FULL;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != SKID);
  end

  // MEM-facing outputs; control bits never assert on a bubble.
  assign in_ready_o       = in_ready_q;
  assign out_valid_o      = main_vld;
  assign reg_write_en_o   = main_vld & main_q[RWE_B];
  assign mem_write_en_o   = main_vld & main_q[MWE_B];
  assign mem_to_reg_o     = main_vld & main_q[M2R_B];
  assign alu_o            = main_q[ALU_LO +: DATA_W];
  assign reg_data2_o      = main_q[RD2_LO +: DATA_W];
  assign reg_write_addr_o = main_q[0 +: ADDR_W];

`ifdef EXMEM_FWD_EN
  // Forward only ALU results headed for a real register; loads are not ready yet.
  assign fwd_valid_o = ~rst_i & main_vld & main_q[RWE_B] & ~main_q[M2R_B] &
                       (main_q[0 +: ADDR_W] != '0);
  assign fwd_addr_o  = rst_i ? '0 : main_q[0 +: ADDR_W];
  assign fwd_data_o  = rst_i ? '0 : main_q[ALU_LO +: DATA_W];
`endif

endmodule

// File: tb/tb_exmem_skid_stage.sv
// Directed bench for exmem_skid_stage with a FIFO scoreboard of accepted payloads.
// Forwarding checks compile in when EXMEM_FWD_EN is defined.
module tb_exmem_skid_stage;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int PW     = 3 + 2 * DATA_W + ADDR_W;

  logic              clk;
  logic              rst_i, flush_i, in_valid_i, in_ready_o;
  logic              reg_write_en_i, mem_write_en_i, mem_to_reg_i;
  logic [DATA_W-1:0] alu_i, reg_data2_i;
  logic [ADDR_W-1:0] reg_write_addr_i;
  logic              out_valid_o, out_ready_i;
  logic              reg_write_en_o, mem_write_en_o, mem_to_reg_o;
  logic [DATA_W-1:0] alu_o, reg_data2_o;
  logic [ADDR_W-1:0] reg_write_addr_o;
`ifdef EXMEM_FWD_EN
  logic              fwd_valid_o;
  logic [ADDR_W-1:0] fwd_addr_o;
  logic [DATA_W-1:0] fwd_data_o;
`endif

  int total = 0;
  int bad   = 0;
  int cons_cnt = 0;
  logic [PW-1:0] sb[$];

  exmem_skid_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .reg_write_en_i(reg_write_en_i), .mem_write_en_i(mem_write_en_i),
    .mem_to_reg_i(mem_to_reg_i), .alu_i(alu_i), .reg_data2_i(reg_data2_i),
    .reg_write_addr_i(reg_write_addr_i),
`ifdef EXMEM_FWD_EN
    .fwd_valid_o(fwd_valid_o), .fwd_addr_o(fwd_addr_o), .fwd_data_o(fwd_data_o),
`endif
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .reg_write_en_o(reg_write_en_o), .mem_write_en_o(mem_write_en_o),
    .mem_to_reg_o(mem_to_reg_o), .alu_o(alu_o), .reg_data2_o(reg_data2_o),
    .reg_write_addr_o(reg_write_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {{(PW-1){1'b0}}, obs}, {{(PW-1){1'b0}}, exp});
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] a,
                       input logic rwe, input logic mwe, input logic m2r);
    in_valid_i       = v;
    alu_i            = a;
    reg_data2_i      = ~a;
    reg_write_addr_i = a[ADDR_W-1:0];
    reg_write_en_i   = rwe;
    mem_write_en_i   = mwe;
    mem_to_reg_i     = m2r;
  endtask

  // One clock: check occupancy-derived handshake, update scoreboard, advance to next negedge.
  task automatic tick();
    logic acc, cons;
    logic [PW-1:0] exp_pay;
    #1;
    chk1("out_valid", out_valid_o, sb.size() != 0);
    chk1("in_ready", in_ready_o, sb.size() < 2);
    if (sb.size() == 0)
      chk("ctrl_gated", {{(PW-3){1'b0}}, reg_write_en_o, mem_write_en_o, mem_to_reg_o}, '0);
    acc  = in_valid_i && (sb.size() < 2) && !flush_i && !rst_i;
    cons = (sb.size() != 0) && out_ready_i && !rst_i;
    if (rst_i) begin
      sb.delete();
    end else begin
      if (cons) begin
        exp_pay = sb.pop_front();
        chk("payload", {reg_write_en_o, mem_write_en_o, mem_to_reg_o,
                        alu_o, reg_data2_o, reg_write_addr_o}, exp_pay);
        cons_cnt++;
      end
      if (flush_i) sb.delete();
      else if (acc)
        sb.push_back({reg_write_en_i, mem_write_en_i, mem_to_reg_i,
                      alu_i, reg_data2_i, reg_write_addr_i});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    out_ready_i = 1'b1;
    for (int k = 0; k < budget && sb.size() != 0; k++) tick();
    chk1("drain_done", sb.size() == 0, 1'b1);
  endtask

  initial begin
    int c0;
    rst_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk1("rst_out_valid", out_valid_o, 1'b0);
    chk1("rst_in_ready", in_ready_o, 1'b1);
    chk("rst_outputs", {reg_write_en_o, mem_write_en_o, mem_to_reg_o,
                        alu_o, reg_data2_o, reg_write_addr_o}, '0);
    @(negedge clk);

    // Streaming at full throughput
    out_ready_i = 1'b1;
    drive(1'b1, 64'hA5, 1'b1, 1'b0, 1'b0);
    tick();
    chk1("first_valid", out_valid_o, 1'b1);
    chk("first_alu", {{(PW-DATA_W){1'b0}}, alu_o}, {{(PW-DATA_W){1'b0}}, 64'hA5});
    c0 = cons_cnt;
    for (int i = 1; i < 16; i++) begin
      drive(1'b1, 64'h1000 + 64'(i) * 64'h0101_0000_0001, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("stream_rate", PW'(cons_cnt - c0), PW'(16));
    chk1("stream_empty", sb.size() == 0, 1'b1);

    // Backpressure into the skid entry, then ignored input while full
    out_ready_i = 1'b0;
    drive(1'b1, 64'd1, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 64'd2, 1'b0, 1'b1, 1'b1); tick();
    #1 chk1("skid_in_ready", in_ready_o, 1'b0);
    drive(1'b1, 64'd3, 1'b1, 1'b0, 1'b0); tick();
    tick();
    drain(6);
    tick();

    // Flush from SKID with an input presented
    out_ready_i = 1'b0;
    drive(1'b1, 64'h11, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 64'h22, 1'b1, 1'b1, 1'b0); tick();
    flush_i = 1'b1;
    drive(1'b1, 64'h99, 1'b1, 1'b1, 1'b0); tick();
    flush_i = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    chk1("flush_valid", out_valid_o, 1'b0);
    chk1("flush_rwe", reg_write_en_o, 1'b0);
    chk1("flush_mwe", mem_write_en_o, 1'b0);
    chk1("flush_ready", in_ready_o, 1'b1);
    chk("flush_hold_alu", {{(PW-DATA_W){1'b0}}, alu_o}, {{(PW-DATA_W){1'b0}}, 64'h11});
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Flush coinciding with a consume: the consumed entry still leaves
    out_ready_i = 1'b0;
    drive(1'b1, 64'h33, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    out_ready_i = 1'b1; flush_i = 1'b1;
    c0 = cons_cnt;
    tick();
    flush_i = 1'b0;
    chk("flush_consume", PW'(cons_cnt - c0), PW'(1));
    tick();

    // Reset while in SKID
    out_ready_i = 1'b0;
    drive(1'b1, 64'h44, 1'b1, 1'b1, 1'b1); tick();
    drive(1'b1, 64'h55, 1'b1, 1'b1, 1'b1); tick();
    rst_i = 1'b1; flush_i = 1'b1; tick();
    rst_i = 1'b0; flush_i = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    chk1("rst2_ready", in_ready_o, 1'b1);
    chk("rst2_outputs", {reg_write_en_o, mem_write_en_o, mem_to_reg_o, out_valid_o,
                         alu_o, reg_data2_o, reg_write_addr_o}, '0);
    tick();

`ifdef EXMEM_FWD_EN
    out_ready_i = 1'b0;
    drive(1'b1, 64'd9, 1'b1, 1'b0, 1'b0);
    reg_write_addr_i = 5'd7;
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    chk1("fwd_valid", fwd_valid_o, 1'b1);
    chk("fwd_addr", PW'(fwd_addr_o), PW'(7));
    chk("fwd_data", PW'(fwd_data_o), PW'(9));
    drain(4);
    out_ready_i = 1'b0;
    drive(1'b1, 64'd9, 1'b1, 1'b0, 1'b0);
    reg_write_addr_i = 5'd0;
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1 chk1("fwd_addr0", fwd_valid_o, 1'b0);
    drain(4);
    out_ready_i = 1'b0;
    drive(1'b1, 64'd9, 1'b1, 1'b0, 1'b1);
    reg_write_addr_i = 5'd7;
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1 chk1("fwd_load", fwd_valid_o, 1'b0);
    drain(4);
`endif

    chk1("final_empty", sb.size() == 0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
